// File: rtl/opr1_sequencer_if.sv
// opr1_sequencer_if: request/result bundle between the operate sequencer and its controller
//   start            accept strobe, honoured only in IDLE or FIN
//   ir, ac_in, l_in  instruction word and AC/LINK values latched on accept
//   busy, done       status; done is a one-cycle pulse in FIN
//   ac_out, l_out    working accumulator and link registers
//   illegal          qualifies done (non-Group-1 IR or RAR+RAL together)
interface opr1_sequencer_if;
  logic        start;
  logic [11:0] ir;
  logic [11:0] ac_in;
  logic        l_in;
  logic        busy;
  logic        done;
  logic [11:0] ac_out;
  logic        l_out;
  logic        illegal;
  modport master (output start, ir, ac_in, l_in, input busy, done, ac_out, l_out, illegal);
  modport slave (input start, ir, ac_in, l_in, output busy, done, ac_out, l_out, illegal);
endinterface

// File: rtl/opr1_sequencer.sv
// opr1_sequencer: steps PDP-8 Group 1 operate microinstructions, one stage per clock
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    opr1_sequencer_if slave: start/ir/ac_in/l_in in, busy/done/ac_out/l_out/illegal out
module opr1_sequencer (
  input logic clk,
  input logic rst_n,
  opr1_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CL, CM, INC, ROT1, ROT2, FIN} state_t;
  state_t state, state_d;
  logic [11:0] ir_q, ac, ac_d;
  logic l, l_d, accept;
  logic [4:0] en_in, en_q;
  logic [12:0] rot;
  // Step enables, bit order CL, CM, INC, ROT1, ROT2; nothing runs outside Group 1
  function automatic logic [4:0] steps(input logic [11:0] ir);
    logic g1, one;
    g1 = ir[11:8] == 4'b1110;
    one = ir[3] ^ ir[2];
    steps = {5{g1}} & {ir[1] & one, one | (ir[1] & ~ir[3] & ~ir[2]), ir[0], ir[5] | ir[4], ir[7] | ir[6]};
  endfunction
  // First enabled step at index k or later; step i lives in state i+1
  function automatic state_t first(input logic [4:0] en, input logic [2:0] k);
    first = FIN;
    for (int i = 4; i >= 0; i--)
      if (en[i] && i >= int'(k)) first = state_t'(3'(i + 1));
  endfunction
  assign accept = bus.start && (state == IDLE || state == FIN);
  assign en_in = steps(bus.ir);
  assign en_q = steps(ir_q);
  // {L', AC'} for RAR, RAL, or byte swap when neither direction is set
  assign rot = ir_q[3] ? {ac[0], l, ac[11:1]} : ir_q[2] ? {ac[11], ac[10:0], l} : {l, ac[5:0], ac[11:6]};
  always_comb begin
    state_d = accept ? first(en_in, 3'd0) : (state == IDLE || state == FIN) ? IDLE : first(en_q, state);
    {l_d, ac_d} = {l, ac};
    if (accept) {l_d, ac_d} = {bus.l_in, bus.ac_in};
    else
      case (state)
        CL:         {l_d, ac_d} = {l & ~ir_q[6], ac & {12{~ir_q[7]}}};
        CM:         {l_d, ac_d} = {l ^ ir_q[4], ac ^ {12{ir_q[5]}}};
        INC:        {l_d, ac_d} = {l, ac} + 13'd1;
        ROT1, ROT2: {l_d, ac_d} = rot;
        default:    ;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ir_q <= '0;
      ac <= '0;
      l <= 1'b0;
    end else begin
      state <= state_d;
      ir_q <= accept ? bus.ir : ir_q;
      ac <= ac_d;
      l <= l_d;
    end
  assign bus.busy = state != IDLE;
  assign bus.done = state == FIN;
  assign bus.ac_out = ac;
  assign bus.l_out = l;
  assign bus.illegal = (state == FIN) && (ir_q[11:8] != 4'b1110 || (ir_q[3] && ir_q[2]));
endmodule

// File: tb/tb_opr1_sequencer.sv
// tb_opr1_sequencer: vector table, hand sequences and randomized ops against a reference model
module tb_opr1_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  opr1_sequencer_if bus ();
  opr1_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] ir;
    logic [11:0] ac;
    logic        l;
    logic [11:0] eac;
    logic        el;
    logic        eil;
    int          lat;
  } vec_t;
  typedef struct {
    logic [11:0] ac;
    logic        l;
    logic        ill;
    int          lat;
  } res_t;
  vec_t tv[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask
  // Applies the rules directly on the 13-bit value {L,AC}
  function automatic res_t model(input logic [11:0] ir, input logic [11:0] ac, input logic l);
    res_t r;
    int v, n, nrot;
    bit g1;
    v = {l, ac};
    n = 0;
    g1 = ir[11:8] == 4'hE;
    r.ill = !g1 || (ir[3] && ir[2]);
    if (g1) begin
      if (ir[7] || ir[6]) begin
        if (ir[7]) v = v & 'h1000;
        if (ir[6]) v = v & 'h0FFF;
        n++;
      end
      if (ir[5] || ir[4]) begin
        if (ir[5]) v = v ^ 'h0FFF;
        if (ir[4]) v = v ^ 'h1000;
        n++;
      end
      if (ir[0]) begin
        v = (v + 1) % 8192;
        n++;
      end
      nrot = (ir[3] != ir[2]) ? (ir[1] ? 2 : 1) : (!ir[3] && !ir[2] && ir[1]) ? 1 : 0;
      for (int j = 0; j < nrot; j++)
        if (ir[3]) v = (v >> 1) | ((v & 1) << 12);
        else if (ir[2]) v = ((v << 1) & 'h1FFF) | (v >> 12);
        else v = (v & 'h1000) | ((v & 63) << 6) | ((v >> 6) & 63);
      n += nrot;
    end
    r.ac = v[11:0];
    r.l = v[12];
    r.lat = n + 1;
    return r;
  endfunction
  // Accepts one op at the current time (DUT must be in IDLE or FIN), sprinkling ignored
  // START pulses and scrambled inputs over the steps; chain leaves the DUT in FIN
  task automatic run(input string nm, input logic [11:0] i, input logic [11:0] a, input logic li,
                     input logic [11:0] ea, input logic el, input logic eil, input int elat, input bit chain);
    int k;
    bit bad;
    bus.start = 1'b1;
    bus.ir = i;
    bus.ac_in = a;
    bus.l_in = li;
    @(posedge clk);
    #1;
    k = 1;
    bad = 0;
    bus.ir = 12'($urandom);
    bus.ac_in = 12'($urandom);
    bus.l_in = 1'($urandom);
    while (!bus.done && k < 10) begin
      if (!bus.busy) bad = 1;
      bus.start = 1'($urandom);
      @(posedge clk);
      #1;
      k++;
    end
    bus.start = 1'b0;
    chk({nm, " latency"}, k, elat);
    chk({nm, " ac"}, bus.ac_out, ea);
    chk({nm, " link"}, bus.l_out, el);
    chk({nm, " illegal"}, bus.illegal, eil);
    chk({nm, " busy_gap"}, bad, 0);
    if (!chain) begin
      @(posedge clk);
      #1;
      chk({nm, " done_drop"}, {bus.done, bus.busy}, 2'b00);
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end
  initial begin
    res_t r;
    logic [11:0] ri, ra;
    logic rl;
    tv[0]  = '{12'o7240, 12'o1234, 1'b0, 12'o7777, 1'b0, 1'b0, 3};
    tv[1]  = '{12'o7001, 12'o7777, 1'b0, 12'o0000, 1'b1, 1'b0, 2};
    tv[2]  = '{12'o7001, 12'o7777, 1'b1, 12'o0000, 1'b0, 1'b0, 2};
    tv[3]  = '{12'o7006, 12'o4000, 1'b0, 12'o0001, 1'b0, 1'b0, 3};
    tv[4]  = '{12'o7002, 12'o1234, 1'b1, 12'o3412, 1'b1, 1'b0, 2};
    tv[5]  = '{12'o7214, 12'o5555, 1'b0, 12'o0000, 1'b0, 1'b1, 2};
    tv[6]  = '{12'o7400, 12'o1234, 1'b1, 12'o1234, 1'b1, 1'b1, 1};
    tv[7]  = '{12'o7010, 12'o0001, 1'b0, 12'o0000, 1'b1, 1'b0, 2};
    tv[8]  = '{12'o7012, 12'o0001, 1'b0, 12'o4000, 1'b0, 1'b0, 3};
    tv[9]  = '{12'o7020, 12'o0707, 1'b0, 12'o0707, 1'b1, 1'b0, 2};
    tv[10] = '{12'o7000, 12'o2525, 1'b1, 12'o2525, 1'b1, 1'b0, 1};
    tv[11] = '{12'o6001, 12'o7777, 1'b0, 12'o7777, 1'b0, 1'b1, 1};
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ir = 12'o7777;
    bus.ac_in = 12'o7777;
    bus.l_in = 1'b1;
    #1;
    chk("reset outputs", {bus.ac_out, bus.l_out, bus.busy, bus.done, bus.illegal}, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle outputs", {bus.ac_out, bus.l_out, bus.busy, bus.done, bus.illegal}, 16'h0);
    foreach (tv[n])
      run($sformatf("vec%0d", n), tv[n].ir, tv[n].ac, tv[n].l, tv[n].eac, tv[n].el, tv[n].eil, tv[n].lat, 1'b0);
    // Back-to-back: 7365 (CL, CM, INC, RAL) chained straight into 7001 from FIN
    run("b2b_first", 12'o7365, 12'o1111, 1'b0, 12'o0000, 1'b0, 1'b0, 5, 1'b1);
    run("b2b_second", 12'o7001, 12'o7777, 1'b0, 12'o0000, 1'b1, 1'b0, 2, 1'b0);
    // Reset while ROT1 of 7006 is in progress
    bus.start = 1'b1;
    bus.ir = 12'o7006;
    bus.ac_in = 12'o4000;
    bus.l_in = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("pre_reset ac", bus.ac_out, 12'o4000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset outputs", {bus.ac_out, bus.l_out, bus.busy, bus.done, bus.illegal}, 16'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("held_reset done", {bus.done, bus.busy}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post_reset", 12'o7001, 12'o0041, 1'b1, 12'o0042, 1'b1, 1'b0, 2, 1'b0);
    for (int n = 0; n < 150; n++) begin
      ri = ($urandom_range(0, 7) == 0) ? 12'($urandom) : {4'b1110, 8'($urandom)};
      ra = 12'($urandom);
      rl = 1'($urandom);
      r = model(ri, ra, rl);
      run($sformatf("rnd%0d ir=%0o", n, ri), ri, ra, rl, r.ac, r.l, r.ill, r.lat, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/opr1_sequencer.md
# opr1_sequencer

Multi-cycle sequencer for PDP-8 Group 1 operate microinstructions (opcode 7, IR bit 3 clear). It latches IR, AC and LINK on a start strobe, then steps the clear, complement, increment and rotate stages in the fixed PDP-8 order, one stage per clock. Stages with no enabled bits are skipped. It sits between the instruction decoder/major-state controller and the AC/LINK registers, and reports completion with a one-cycle DONE pulse. All values below are octal unless marked otherwise.

## Interface
- No parameters; word width is fixed at 12 bits, LINK at 1 bit.
- CLK  in  1  system clock; all state changes on the rising edge.
- nRESET  in  1  reset, asynchronous assert, active-low.
- START  in  1  request strobe; sampled only in IDLE or FIN.
- IR  in  12  instruction word; IR[11] is DEC bit 0.
- AC_IN  in  12  accumulator value, latched with START.
- L_IN  in  1  link value, latched with START.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  high for exactly one cycle, in FIN.
- AC_OUT  out  12  working accumulator register.
- L_OUT  out  1  working link register.
- ILLEGAL  out  1  qualifies DONE; high only in FIN.

## Operation
- Field decode:
  - Group 1 is IR[11:8]=1110.
  - Control bits: IR[7] CLA, IR[6] CLL, IR[5] CMA, IR[4] CML, IR[3] RAR, IR[2] RAL, IR[1] BSW/double, IR[0] IAC.
- Accept:
  - START=1 in IDLE or FIN loads IR, AC_IN and L_IN into the internal registers.
  - Next state is the first enabled step, or FIN if no step is enabled.
- States, in this order: IDLE, CL, CM, INC, ROT1, ROT2, FIN. Disabled states are skipped.
- CL (enabled if CLA|CLL): AC &= {12{~CLA}}; L &= ~CLL.
- CM (enabled if CMA|CML): AC ^= {12{CMA}}; L ^= CML.
- INC (enabled if IAC): {L,AC} treated as 13 bits, AC = AC+1 mod 10000. L toggles iff AC was 7777 before the increment.
- ROT1 (enabled if exactly one of RAR/RAL is set, or if IR[1]=1 with RAR=RAL=0):
  - RAR: L'=AC[0], AC'={L,AC[11:1]}.
  - RAL: L'=AC[11], AC'={AC[10:0],L}.
  - BSW alone: AC'={AC[5:0],AC[11:6]}; L unchanged.
- ROT2 (enabled if IR[1]=1 and exactly one of RAR/RAL is set): repeats the ROT1 rotation (RTR/RTL).
- RAR and RAL both set:
  - ROT1 and ROT2 are skipped.
  - ILLEGAL=1 in FIN.
  - CL, CM and INC still execute.
- Non-Group-1 IR:
  - No steps execute and AC/L keep the latched inputs.
  - FIN follows immediately, with ILLEGAL=1.
- FIN: DONE=1 and BUSY=1. Next state is IDLE, or a new accept if START=1.
- START in CL/CM/INC/ROT1/ROT2 is ignored. It is not queued.

## Timing
- Reset (async, nRESET low) forces:
  - state IDLE;
  - AC_OUT=0000, L_OUT=0;
  - BUSY=0, DONE=0, ILLEGAL=0.
- Reset mid-operation aborts with no DONE. Operation resumes on the first CLK edge after nRESET rises.
- Latency: START sampled at edge 0, DONE high during cycle N+1, where N is the number of enabled steps (0..5).
- AC_OUT/L_OUT are updated at the end of each step, are final during FIN, and are held until the next accept.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- Back-to-back: START during FIN is accepted. DONE deasserts the next cycle and BUSY stays high.
- IR/AC_IN/L_IN may change freely after the accept edge without affecting the operation.

## Test plan
- Complement: IR=7240 (CLA CMA), AC_IN=1234, L_IN=0 -> CL and CM steps; DONE in cycle 3, AC_OUT=7777, L_OUT=0, ILLEGAL=0.
- Increment wrap: IR=7001 (IAC), AC_IN=7777, L_IN=0 -> DONE in cycle 2, AC_OUT=0000, L_OUT=1. Repeat with L_IN=1 -> L_OUT=0.
- Rotate and swap:
  - IR=7006 (RTL), AC_IN=4000, L_IN=0 -> ROT1 gives L=1, AC=0000; ROT2 gives L=0, AC=0001; DONE in cycle 3.
  - IR=7002 (BSW), AC_IN=1234, L_IN=1 -> AC_OUT=3412, L_OUT=1; DONE in cycle 2.
- Illegal encodings:
  - IR=7214 (CLA RAR RAL), AC_IN=5555 -> AC_OUT=0000, rotation skipped, DONE in cycle 2 with ILLEGAL=1.
  - IR=7400 -> DONE in cycle 1, ILLEGAL=1, AC_OUT=AC_IN.
- Handshake: IR=7365 accepted; START pulses during the steps are ignored and exactly one DONE is produced. START asserted in FIN with IR=7001 -> second DONE follows with no IDLE cycle between.
- Reset: assert nRESET low mid-ROT1 of 7006 -> outputs go to 0 immediately with no DONE. A new 7001 after release completes normally.
